// File: rtl/sd_response_gate.sv
// Gate that stays high while counting SD clock edges and drops once a masked
// CMD response pattern is seen past an edge threshold, or on edge timeout.
module sd_response_gate #(
  parameter int unsigned       RESP_W        = 16,
  parameter logic [RESP_W-1:0] PATTERN       = 16'h01AA,
  parameter logic [RESP_W-1:0] MASK          = 16'h0FFF,
  parameter int unsigned       CNT_W         = 16,
  parameter int unsigned       EDGE_THRESH   = 193,
  parameter int unsigned       RESEND_COUNT  = 80,
  parameter int unsigned       TIMEOUT_EDGES = 1024,
  parameter int unsigned       SYNC_STAGES   = 2
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             sd_clk_in,
  input  logic             sd_cmd_in,
  input  logic             enable,
  input  logic             resend,
  output logic             gate_signal,
  output logic             match_pulse,
  output logic             timeout,
  output logic [CNT_W-1:0] edge_count,
  output logic [1:0]       state_o
);

  // state   | meaning
  // IDLE    | disarmed, counter and shift register held
  // COUNT   | counting SD clock rises and shifting CMD bits, gate high
  // MATCHED | response pattern accepted, gate low until resend/disable
  // TIMEOUT | edge budget exhausted without a match
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COUNT   = 2'd1,
    S_MATCHED = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [SYNC_STAGES-1:0] clk_sync_r, cmd_sync_r;
  logic              clk_d;
  logic              clk_sync, cmd_sync, rise;
  logic [RESP_W-1:0] shreg, sh_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [31:0]       cnt_ext;
  logic              match;

  assign clk_sync = clk_sync_r[SYNC_STAGES-1];
  assign cmd_sync = cmd_sync_r[SYNC_STAGES-1];
  assign rise     = clk_sync & ~clk_d;
  assign match    = ((shreg ^ PATTERN) & MASK) == '0;
  assign cnt_ext  = 32'(edge_count);
  assign state_o  = state;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = edge_count;
    sh_nxt    = shreg;
    if (!enable) begin
      state_nxt = S_IDLE;
    end else if (resend && state != S_IDLE) begin
      // a retry restarts from a fixed offset and discards any coincident edge
      state_nxt = S_COUNT;
      cnt_nxt   = CNT_W'(RESEND_COUNT);
      sh_nxt    = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt = S_COUNT;
          cnt_nxt   = '0;
          sh_nxt    = '0;
        end
        S_COUNT: begin
          if (match && cnt_ext > EDGE_THRESH)
            state_nxt = S_MATCHED;
          else if (cnt_ext >= TIMEOUT_EDGES)
            state_nxt = S_TIMEOUT;
          if (rise) begin
            sh_nxt = {shreg[RESP_W-2:0], cmd_sync};
            if (edge_count != '1)
              cnt_nxt = edge_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_sync_r  <= '0;
      cmd_sync_r  <= '0;
      clk_d       <= 1'b0;
      state       <= S_IDLE;
      edge_count  <= '0;
      shreg       <= '0;
      gate_signal <= 1'b0;
      match_pulse <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], sd_clk_in};
      cmd_sync_r  <= {cmd_sync_r[SYNC_STAGES-2:0], sd_cmd_in};
      clk_d       <= clk_sync;
      state       <= state_nxt;
      edge_count  <= cnt_nxt;
      shreg       <= sh_nxt;
      gate_signal <= (state_nxt == S_COUNT);
      match_pulse <= (state == S_COUNT) && (state_nxt == S_MATCHED);
      timeout     <= (state_nxt == S_TIMEOUT);
    end
  end

endmodule

// File: tb/tb_sd_response_gate.sv
// Randomised SD edge stimulus against a transaction-level reference model,
// run on a default instance and on a narrow-counter instance in parallel.
module tb_sd_response_gate;

  localparam logic [15:0] PAT = 16'h01AA;
  localparam logic [15:0] MSK = 16'h0FFF;
  localparam int THR = 193;
  localparam int RSC = 80;

  logic clk = 1'b0;
  logic reset, sd_clk, sd_cmd, enable, resend;
  logic gate_w[2], mp_w[2], to_w[2];
  logic [1:0] so_w[2];
  logic [15:0] ec0;
  logic [7:0]  ec1;

  int total = 0;
  int bad = 0;
  int mp_cnt[2] = '{0, 0};
  int viol = 0;

  int m_state[2];
  int m_cnt[2];
  logic [15:0] m_sh[2];
  int m_match[2] = '{0, 0};
  int cmax[2] = '{65535, 255};
  int tout[2] = '{1024, 300};

  always #10 clk = ~clk;

  sd_response_gate dut0 (
    .CLOCK_50(clk), .reset(reset), .sd_clk_in(sd_clk), .sd_cmd_in(sd_cmd),
    .enable(enable), .resend(resend), .gate_signal(gate_w[0]),
    .match_pulse(mp_w[0]), .timeout(to_w[0]), .edge_count(ec0), .state_o(so_w[0])
  );

  sd_response_gate #(.CNT_W(8), .TIMEOUT_EDGES(300)) dut1 (
    .CLOCK_50(clk), .reset(reset), .sd_clk_in(sd_clk), .sd_cmd_in(sd_cmd),
    .enable(enable), .resend(resend), .gate_signal(gate_w[1]),
    .match_pulse(mp_w[1]), .timeout(to_w[1]), .edge_count(ec1), .state_o(so_w[1])
  );

  // cycle-level invariants between state and the registered flags
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mp_w[k] === 1'b1) mp_cnt[k]++;
      if (gate_w[k] !== (so_w[k] == 2'd1)) viol++;
      if (to_w[k] !== (so_w[k] == 2'd3)) viol++;
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.state%0d", tag, k), 32'(so_w[k]), m_state[k]);
      chk($sformatf("%s.count%0d", tag, k), (k == 0) ? 32'(ec0) : 32'(ec1), m_cnt[k]);
      chk($sformatf("%s.gate%0d", tag, k), 32'(gate_w[k]), (m_state[k] == 1) ? 1 : 0);
      chk($sformatf("%s.tout%0d", tag, k), 32'(to_w[k]), (m_state[k] == 3) ? 1 : 0);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // reference: one counted SD edge, then the accept/timeout decision
  task automatic model_edge(logic b);
    for (int k = 0; k < 2; k++) begin
      if (m_state[k] == 1) begin
        m_sh[k] = {m_sh[k][14:0], b};
        if (m_cnt[k] < cmax[k]) m_cnt[k]++;
        if ((((m_sh[k] ^ PAT) & MSK) == 16'h0) && m_cnt[k] > THR) begin
          m_state[k] = 2;
          m_match[k]++;
        end else if (m_cnt[k] >= tout[k]) begin
          m_state[k] = 3;
        end
      end
    end
  endtask

  task automatic model_resend();
    for (int k = 0; k < 2; k++)
      if (m_state[k] != 0) begin
        m_state[k] = 1;
        m_cnt[k] = RSC;
        m_sh[k] = 16'h0;
      end
  endtask

  task automatic sd_edge(logic b);
    int h;
    h = $urandom_range(6, 9);
    sd_clk = 1'b0;
    sd_cmd = b;
    tick(h);
    sd_clk = 1'b1;
    tick(h);
    model_edge(b);
  endtask

  task automatic do_resend();
    resend = 1'b1;
    tick(1);
    resend = 1'b0;
    model_resend();
  endtask

  initial begin
    logic b;
    logic [15:0] pat_v, flip_v;
    pat_v = PAT;
    flip_v = PAT ^ 16'h0008;
    reset = 1'b1; enable = 1'b0; resend = 1'b0; sd_clk = 1'b0; sd_cmd = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_cnt[k] = 0; m_sh[k] = 16'h0;
    end
    tick(3);
    check_all("reset");
    reset = 1'b0;
    tick(2);
    check_all("idle");
    enable = 1'b1;
    tick(1);
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 1; m_cnt[k] = 0; m_sh[k] = 16'h0;
    end
    check_all("arm");

    // pattern lands at edge 200 with 4'hF above the masked field
    for (int e = 1; e <= 300 && m_state[0] == 1; e++) begin
      if (e >= 185 && e <= 188) b = 1'b1;
      else if (e >= 189 && e <= 200) b = pat_v[200 - e];
      else b = 1'($urandom_range(0, 1));
      sd_edge(b);
      check_all("match_a");
    end
    tick(2);
    chk("pulse0_a", mp_cnt[0], m_match[0]);
    chk("pulse1_a", mp_cnt[1], m_match[1]);

    do_resend();
    check_all("resend");

    // edge coinciding with a resend is discarded
    sd_clk = 1'b0; sd_cmd = 1'b1;
    tick(6);
    sd_clk = 1'b1;
    tick(2);
    resend = 1'b1;
    tick(1);
    resend = 1'b0;
    model_resend();
    tick(6);
    check_all("resend_edge");

    // pattern at count 193 is ignored, again at 210 it is accepted
    for (int n = 1; n <= 200 && m_state[0] == 1; n++) begin
      if (n >= 102 && n <= 113) b = pat_v[113 - n];
      else if (n >= 119 && n <= 130) b = pat_v[130 - n];
      else b = 1'($urandom_range(0, 1));
      sd_edge(b);
      check_all("match_b");
    end
    tick(2);
    chk("pulse0_b", mp_cnt[0], m_match[0]);
    chk("pulse1_b", mp_cnt[1], m_match[1]);

    do_resend();
    for (int n = 0; n < 40; n++) sd_edge(1'($urandom_range(0, 1)));
    check_all("pre_disable");
    enable = 1'b0;
    tick(1);
    for (int k = 0; k < 2; k++) m_state[k] = 0;
    check_all("disable");
    tick(3);
    check_all("disable_hold");
    enable = 1'b1;
    tick(1);
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 1; m_cnt[k] = 0; m_sh[k] = 16'h0;
    end
    check_all("reenable");

    // early pattern, bit-3 corrupted pattern, then idle-high CMD to timeout
    for (int n = 1; n <= 1100 && m_state[0] == 1; n++) begin
      if (n >= 139 && n <= 150) b = pat_v[150 - n];
      else if (n >= 239 && n <= 250) b = flip_v[250 - n];
      else if (n < 139) b = 1'($urandom_range(0, 1));
      else b = 1'b1;
      sd_edge(b);
      check_all("timeout");
    end

    do_resend();
    check_all("resend_to");
    for (int n = 0; n < 420; n++) sd_edge(1'b1);
    check_all("sat");

    reset = 1'b1;
    tick(1);
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_cnt[k] = 0; m_sh[k] = 16'h0;
    end
    check_all("mid_reset");
    chk("mp0_reset", 32'(mp_w[0]), 0);
    chk("mp1_reset", 32'(mp_w[1]), 0);
    reset = 1'b0;
    tick(1);
    for (int k = 0; k < 2; k++) m_state[k] = 1;
    check_all("post_reset");

    tick(2);
    chk("pulse0_end", mp_cnt[0], m_match[0]);
    chk("pulse1_end", mp_cnt[1], m_match[1]);
    chk("invariants", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
